// File: rtl/mc_ctrl_pkg.sv
// Shared types and opcode map for the multicycle controller.
// Opcode groups are contiguous so decode is a simple range check.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_FP_WAIT,
        ST_MEM_WAIT,
        ST_ERROR
    } state_e;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOT   = 4'h5;
    localparam logic [3:0] OP_SHL   = 4'h6;
    localparam logic [3:0] OP_SHR   = 4'h7;
    localparam logic [3:0] OP_FADD  = 4'h8;
    localparam logic [3:0] OP_FSUB  = 4'h9;
    localparam logic [3:0] OP_FMUL  = 4'hA;
    localparam logic [3:0] OP_LOAD  = 4'hB;
    localparam logic [3:0] OP_STORE = 4'hC;
    localparam logic [3:0] OP_BEQ   = 4'hD;
    localparam logic [3:0] OP_BNE   = 4'hE;
    localparam logic [3:0] OP_JMP   = 4'hF;

    localparam logic [3:0] INT_LO = OP_ADD;
    localparam logic [3:0] INT_HI = OP_SHR;
    localparam logic [3:0] FP_LO  = OP_FADD;
    localparam logic [3:0] FP_HI  = OP_FMUL;
    localparam logic [3:0] MEM_LO = OP_LOAD;
    localparam logic [3:0] MEM_HI = OP_STORE;

    // Wrapping subtraction keeps the check free of constant compares.
    function automatic logic in_range(
        input logic [3:0] op,
        input logic [3:0] lo,
        input logic [3:0] hi
    );
        return (op - lo) <= (hi - lo);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Handshake wait counter; flags the last allowed waiting cycle.
import mc_ctrl_pkg::*;

module mc_wait_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mc_controller.sv
// Multicycle CPU control FSM: fetch/decode/execute with FP and
// memory handshake waits guarded by a timeout.
import mc_ctrl_pkg::*;

module mc_controller #(
    parameter int OPW         = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           fp_done,
    input  logic           mem_ready,
    output logic           loadA,
    output logic           loadB,
    output logic           loadC,
    output logic           loadIR,
    output logic           loadPC,
    output logic           incPC,
    output logic           mode,
    output logic           we_DM,
    output logic           selA,
    output logic           selB,
    output logic           fp_start,
    output logic           busy,
    output logic           err
);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] op_q;
    logic       waiting;
    logic       tmo;
    logic       bad_op;
    logic       take;

    assign waiting = (state_q == ST_FP_WAIT) || (state_q == ST_MEM_WAIT);
    assign bad_op  = (opcode >> 4) != '0;
    assign take    = (op_q == OP_BEQ) ? zero : !zero;

    mc_wait_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (en && !waiting),
        .en     (en && waiting),
        .expired(tmo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            op_q    <= '0;
        end else if (en) begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= opcode[3:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        loadA    = 1'b0;
        loadB    = 1'b0;
        loadC    = 1'b0;
        loadIR   = 1'b0;
        loadPC   = 1'b0;
        incPC    = 1'b0;
        mode     = 1'b0;
        we_DM    = 1'b0;
        selA     = 1'b0;
        selB     = 1'b0;
        fp_start = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                loadIR  = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: state_d = bad_op ? ST_ERROR : ST_EXECUTE;
            ST_EXECUTE: begin
                state_d = ST_FETCH;
                unique case (1'b1)
                    in_range(op_q, INT_LO, INT_HI): begin
                        loadC = 1'b1;
                        incPC = 1'b1;
                    end
                    in_range(op_q, FP_LO, FP_HI): begin
                        fp_start = 1'b1;
                        mode     = 1'b1;
                        state_d  = ST_FP_WAIT;
                    end
                    in_range(op_q, MEM_LO, MEM_HI): state_d = ST_MEM_WAIT;
                    (op_q == OP_JMP): begin
                        loadPC = 1'b1;
                        selA   = 1'b1;
                        selB   = 1'b1;
                    end
                    default: begin
                        loadPC = take;
                        selA   = take;
                        incPC  = !take;
                    end
                endcase
            end
            ST_FP_WAIT: begin
                mode = 1'b1;
                if (fp_done) begin
                    loadC   = 1'b1;
                    incPC   = 1'b1;
                    state_d = ST_FETCH;
                end else if (tmo) begin
                    state_d = ST_ERROR;
                end
            end
            ST_MEM_WAIT: begin
                we_DM = (op_q == OP_STORE);
                if (mem_ready) begin
                    loadA   = (op_q == OP_LOAD);
                    incPC   = 1'b1;
                    state_d = ST_FETCH;
                end else if (tmo) begin
                    state_d = ST_ERROR;
                end
            end
            ST_ERROR: err = 1'b1;
            default: state_d = ST_ERROR;
        endcase
        busy = (state_q != ST_RESET) && (state_q != ST_ERROR);
        // A stall keeps only the status flags visible.
        if (!en) begin
            loadA    = 1'b0;
            loadB    = 1'b0;
            loadC    = 1'b0;
            loadIR   = 1'b0;
            loadPC   = 1'b0;
            incPC    = 1'b0;
            mode     = 1'b0;
            we_DM    = 1'b0;
            selA     = 1'b0;
            selB     = 1'b0;
            fp_start = 1'b0;
        end
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter OPW, default 4: opcode width; must be at least 4.
REQ-002 Parameter TIMEOUT_CYC, default 16: maximum wait cycles for the FP or memory handshake before error; must be at least 2.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 en  input  1  run enable; 0 = stall (state and counters hold, all strobes 0).
REQ-006 opcode  input  OPW  instruction opcode from IR; valid in DECODE.
REQ-007 zero  input  1  ALU zero flag, used by BEQ/BNE in EXECUTE.
REQ-008 fp_done  input  1  FPU completion pulse.
REQ-009 mem_ready  input  1  data-memory ready.
REQ-010 Outputs, 1 bit each: loadA, loadB, loadC, loadIR, loadPC, incPC, mode, we_DM, selA, selB, fp_start, busy, err.

Function
REQ-011 States SHALL be RESET, FETCH, DECODE, EXECUTE, FP_WAIT, MEM_WAIT, ERROR; outputs are a combinational decode of the state and the latched opcode.
REQ-012 Transitions SHALL be:
- RESET->FETCH.
- FETCH->DECODE, with loadIR=1 for one cycle.
- DECODE->EXECUTE, latching opcode internally.
- EXECUTE->FETCH for single-cycle ops, ->FP_WAIT for FP ops, ->MEM_WAIT for LOAD/STORE.
REQ-013 Integer ops 0x0-0x7: EXECUTE asserts loadC=1, incPC=1, mode=0 for one cycle.
REQ-014 FP ops 0x8-0xA:
- EXECUTE asserts fp_start=1 (exactly one cycle) and mode=1.
- FP_WAIT holds mode=1.
- In the cycle fp_done=1, asserts loadC=1 and incPC=1, then goes to FETCH.
REQ-015 LOAD 0xB: MEM_WAIT; in the cycle mem_ready=1, asserts loadA=1 and incPC=1, then goes to FETCH.
REQ-016 STORE 0xC: we_DM=1 throughout MEM_WAIT, including the mem_ready cycle, which also asserts incPC=1 and then goes to FETCH.
REQ-017 BEQ 0xD: zero=1 gives loadPC=1, selA=1; otherwise incPC=1. BNE 0xE uses the inverted condition.
REQ-018 JMP 0xF: loadPC=1, selA=1, selB=1.
REQ-019 loadPC and incPC SHALL never be 1 in the same cycle.
REQ-020 An opcode with any bit above bit 3 set (OPW>4) SHALL go to ERROR.
REQ-021 The wait counter SHALL clear on entry to FP_WAIT/MEM_WAIT and increment each waiting cycle. If the count reaches TIMEOUT_CYC-1 without the handshake, the next state is ERROR.
REQ-022 If the handshake and the final count occur in the same cycle, the handshake wins and completes normally.
REQ-023 ERROR: err=1 and all strobes 0; the block stays in ERROR until rst.
REQ-024 busy=1 in every state except RESET and ERROR.
REQ-025 mode SHALL be a defined 0/1, never Z; it is 0 outside FP states.
REQ-026 en=0 in any state SHALL freeze state, the latched opcode and the counter, and force all strobes and fp_start to 0.
REQ-027 On resume with en=1, the frozen state's outputs SHALL re-evaluate; fp_start SHALL NOT re-fire in FP_WAIT.

Reset
REQ-028 rst=1 at a clock edge SHALL set the state to RESET, clear the counter, err and the latched opcode, and drive every output to 0, with priority over en.
REQ-029 rst during FP_WAIT or MEM_WAIT SHALL abandon the transaction; we_DM is 0 from the cycle after the reset edge.

Structure
REQ-030 Package mc_ctrl_pkg SHALL hold:
- the state enumeration;
- the opcode constants OP_ADD..OP_JMP;
- the range limits for the integer, FP and memory opcode groups.
REQ-031 Sub-module mc_wait_timer (parameter TIMEOUT_CYC; ports clk, rst, clr, en, expired) SHALL implement the counter for REQ-021.

Verification
REQ-032 ADD (0x0), en=1 after reset: loadIR in cycle 2, loadC=incPC=1 in cycle 4, FETCH again in cycle 5.
REQ-033 FADD (0x8), fp_done raised 3 cycles after fp_start: one fp_start pulse, mode=1 for 4 cycles, loadC=incPC=1 exactly in the fp_done cycle.
REQ-034 STORE (0xC), mem_ready low for TIMEOUT_CYC cycles: we_DM=1 until the timeout, then err=1, busy=0, all strobes 0 until rst.
REQ-035 BEQ with zero=1: loadPC=1, selA=1, incPC=0. BNE with zero=1: incPC=1, loadPC=0.
REQ-036 en=0 for 5 cycles mid-MEM_WAIT of LOAD, then mem_ready=1 after resume: no timeout, loadA=1 once.
REQ-037 rst=1 mid-FP_WAIT: next cycle all outputs 0, state RESET, no loadC.
